// File: rtl/pcm_rom_arbiter_if.sv
// pcm_rom_arbiter_if
// Bundles the two fetcher REQ/ACK ports and the PCM ROM pins that
// pcm_rom_arbiter connects together.
//   REQ_A/REQ_B     fetcher read request (level)
//   ADDR_A/ADDR_B   fetcher byte address, held while REQ is high
//   ACK_A/ACK_B     one-cycle pulse, DATA_x valid
//   DATA_A/DATA_B   read data, held until the next ACK on that port
//   A, nROE, D      ROM address, active-low output enable, ROM data
//   BUSY, GRANT     arbiter status (GRANT: 0 = port A, 1 = port B)
// The slave modport is the arbiter's view. The master modport is the view
// of the fetchers plus the ROM.
`timescale 1ns/1ps
interface pcm_rom_arbiter_if;
  logic        REQ_A;
  logic [23:0] ADDR_A;
  logic        ACK_A;
  logic [7:0]  DATA_A;
  logic        REQ_B;
  logic [23:0] ADDR_B;
  logic        ACK_B;
  logic [7:0]  DATA_B;
  logic [23:0] A;
  logic        nROE;
  logic [7:0]  D;
  logic        BUSY;
  logic        GRANT;

  modport slave (
    input  REQ_A, ADDR_A, REQ_B, ADDR_B, D,
    output ACK_A, DATA_A, ACK_B, DATA_B, A, nROE, BUSY, GRANT
  );

  modport master (
    output REQ_A, ADDR_A, REQ_B, ADDR_B, D,
    input  ACK_A, DATA_A, ACK_B, DATA_B, A, nROE, BUSY, GRANT
  );
endinterface

// File: rtl/pcm_rom_arbiter.sv
// pcm_rom_arbiter
// Round-robin sequencer for the shared 24-bit PCM sample ROM. Each access
// follows the same sequence: IDLE (grant), SETUP (address settles with
// nROE high), WAIT_CYCLES of STROBE with nROE low, and DONE (ACK pulse).
// The byte is captured on the clock edge that ends the last STROBE cycle.
// Ports:
//   CLK_68KCLKB  block clock, rising edge
//   RESET        synchronous, active-high
//   bus          pcm_rom_arbiter_if.slave (fetcher ports + ROM pins)
// Parameter:
//   WAIT_CYCLES  cycles nROE is held low per access, 1..15
`timescale 1ns/1ps
module pcm_rom_arbiter #(
  parameter int WAIT_CYCLES = 3
) (
  input logic             CLK_68KCLKB,
  input logic             RESET,
  pcm_rom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last;    // port that completed the most recent access
  logic       pick_b;  // IDLE arbitration result

  // A tie goes to the port that did not win last time. LAST resets to B,
  // so A wins the first tie.
  always_comb begin
    pick_b = (bus.REQ_A && bus.REQ_B) ? ~last : bus.REQ_B;
  end

  always_ff @(posedge CLK_68KCLKB) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last       <= 1'b1;
      bus.A      <= 24'd0;
      bus.nROE   <= 1'b1;
      bus.ACK_A  <= 1'b0;
      bus.ACK_B  <= 1'b0;
      bus.DATA_A <= 8'd0;
      bus.DATA_B <= 8'd0;
      bus.BUSY   <= 1'b0;
      bus.GRANT  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A keeps its previous value while idle.
          if (bus.REQ_A || bus.REQ_B) begin
            bus.A     <= pick_b ? bus.ADDR_B : bus.ADDR_A;
            bus.GRANT <= pick_b;
            bus.BUSY  <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          cnt      <= CNT_LOAD;
          bus.nROE <= 1'b0;
          state    <= STROBE;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            bus.nROE <= 1'b1;
            last     <= bus.GRANT;
            if (bus.GRANT) begin
              bus.DATA_B <= bus.D;
              bus.ACK_B  <= 1'b1;
            end else begin
              bus.DATA_A <= bus.D;
              bus.ACK_A  <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          bus.ACK_A <= 1'b0;
          bus.ACK_B <= 1'b0;
          bus.BUSY  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
